// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the execute stage and a 16-bit,
// word-addressed data memory with a one-cycle synchronous read.
//
// Byte-addressed requests are translated to word accesses. Byte loads are
// zero- or sign-extended. Byte stores use a read-modify-write of the
// containing word. Misaligned word accesses return an error and never touch
// memory. Every accepted request produces exactly one response pulse.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   clk_en             global enable; no state changes while low
//   req_valid/ready    request handshake (ready only in IDLE)
//   req_we, req_byte   store / byte-access qualifiers
//   req_signed         sign-extend byte loads
//   req_addr           byte address (ADDR_WIDTH+1 bits)
//   req_wdata          store data (byte stores use [7:0])
//   resp_valid         one-cycle response pulse
//   resp_rdata         load result (0 for stores and errors)
//   resp_err           misaligned word access
//   mem_raddr          memory read address
//   mem_waddr/wdata/we memory write port
//   mem_rdata          memory read data, valid one cycle after mem_raddr
module dmem_lsu #(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_byte,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH:0]   req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  resp_valid,
  output logic [15:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [15:0]           mem_wdata,
  output logic                  mem_we,
  input  logic [15:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, RMW} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wa_p1;
  logic [ADDR_WIDTH-1:0]   raddr_p1;
  logic                    lane_p1;
  logic                    sgn_p1;
  logic                    byte_p1;
  logic [7:0]              data_p1;

  logic                    accept;
  logic                    misaligned;
  logic                    word_store;
  logic                    rmw_write;
  logic [ADDR_WIDTH-1:0]   req_wa;

  // Pick the addressed lane of a word and extend it to 16 bits.
  function automatic logic [15:0] format_load(input logic [15:0] word,
                                              input logic        is_byte,
                                              input logic        lane,
                                              input logic        sext);
    logic signed [7:0]  lane_s;
    logic signed [15:0] ext_s;
    lane_s = lane ? word[15:8] : word[7:0];
    ext_s  = 16'(lane_s);
    if (!is_byte)
      return word;
    else if (sext)
      return ext_s;
    else
      return {8'h00, lane_s};
  endfunction

  // Replace one byte lane of a word with new store data.
  function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                             input logic        lane,
                                             input logic [7:0]  data);
    return lane ? {data, word[7:0]} : {word[15:8], data};
  endfunction

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready & clk_en;
  assign req_wa     = req_addr[ADDR_WIDTH:1];
  assign misaligned = ~req_byte & req_addr[0];
  assign word_store = accept & req_we & ~req_byte & ~req_addr[0];
  assign rmw_write  = (state == RMW) & clk_en;

  // Write port is combinational so word stores complete in their accept
  // cycle; rst gates it so a reset landing mid-RMW cannot corrupt memory.
  assign mem_we    = ~rst & (word_store | rmw_write);
  assign mem_waddr = (state == RMW) ? wa_p1 : req_wa;
  assign mem_wdata = (state == RMW) ? merge_byte(mem_rdata, lane_p1, data_p1)
                                    : req_wdata;
  // Read address follows the request on accept, otherwise holds.
  assign mem_raddr = accept ? req_wa : raddr_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      wa_p1      <= '0;
      raddr_p1   <= '0;
      lane_p1    <= 1'b0;
      sgn_p1     <= 1'b0;
      byte_p1    <= 1'b0;
      data_p1    <= '0;
    end else if (clk_en) begin
      resp_valid <= 1'b0;
      case (state)
        // Stage p0 -> p1: accept request, latch it for two-cycle operations
        IDLE: begin
          if (req_valid) begin
            raddr_p1 <= req_wa;
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we && !req_byte) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b0;
              resp_rdata <= '0;
            end else begin
              wa_p1   <= req_wa;
              lane_p1 <= req_addr[0];
              sgn_p1  <= req_signed;
              byte_p1 <= req_byte;
              data_p1 <= req_wdata[7:0];
              state   <= req_we ? RMW : LOAD;
            end
          end
        end
        // Stage p1 -> p2: memory data available, format and respond
        LOAD: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= format_load(mem_rdata, byte_p1, lane_p1, sgn_p1);
          state      <= IDLE;
        end
        RMW: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          clk_en;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_byte;
  logic          req_signed;
  logic [AW:0]   req_addr;
  logic [15:0]   req_wdata;
  logic          resp_valid;
  logic [15:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic [15:0]   mem_rdata;

  logic [15:0] dmem    [0:(1<<AW)-1];
  logic [15:0] ref_mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  dmem_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: synchronous write, one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_we) dmem[mem_waddr] <= mem_wdata;
    mem_rdata <= dmem[mem_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: transaction-level effect of one request on memory and response.
  task automatic model(input logic we, input logic bt, input logic sg,
                       input logic [AW:0] addr, input logic [15:0] wd,
                       output logic [15:0] rd, output logic er, output int lat);
    int wa, sh, w, b;
    wa = int'(addr) / 2;
    sh = (int'(addr) % 2) * 8;
    w  = int'(ref_mem[wa]);
    rd = 16'h0;
    er = 1'b0;
    if (!bt && (int'(addr) % 2 == 1)) begin
      er = 1'b1; lat = 1;
    end else if (we && !bt) begin
      ref_mem[wa] = wd; lat = 1;
    end else if (we) begin
      w = (w & ~(255 << sh)) | ((int'(wd) & 255) << sh);
      ref_mem[wa] = 16'(w); lat = 2;
    end else begin
      b = (w >> sh) & 255;
      if (!bt) rd = 16'(w);
      else if (sg && b >= 128) rd = 16'(b + 65280);
      else rd = 16'(b);
      lat = 2;
    end
  endtask

  // mode: 0 = clk_en always high, 1 = random clk_en while waiting, 2 = one
  // disabled cycle then enabled.
  task automatic do_req(input logic we, input logic bt, input logic sg,
                        input logic [AW:0] addr, input logic [15:0] wd,
                        input int mode, input bit use_exp,
                        input logic [15:0] t_rd, input logic t_er, input string tag);
    logic [15:0]   m_rd, e_rd, rmw_wd;
    logic          m_er, e_er, pv;
    logic [AW-1:0] wa;
    int            lat;
    bit            done, en, rmw;
    wa = addr[AW:1];
    model(we, bt, sg, addr, wd, m_rd, m_er, lat);
    e_rd   = use_exp ? t_rd : m_rd;
    e_er   = use_exp ? t_er : m_er;
    rmw    = we && bt;
    rmw_wd = ref_mem[wa];

    @(negedge clk);
    clk_en = 1'b1; req_valid = 1'b1; req_we = we; req_byte = bt;
    req_signed = sg; req_addr = addr; req_wdata = wd;
    #1;
    chk({tag, " ready"}, req_ready, 1);
    if (lat == 1 && !e_er) begin
      chk({tag, " we"}, mem_we, 1);
      chk({tag, " waddr"}, mem_waddr, wa);
      chk({tag, " wdata"}, mem_wdata, wd);
    end else begin
      chk({tag, " we idle"}, mem_we, 0);
    end
    if (lat == 2) chk({tag, " raddr"}, mem_raddr, wa);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (lat == 1) begin
      chk({tag, " valid"}, resp_valid, 1);
      chk({tag, " rdata"}, resp_rdata, e_rd);
      chk({tag, " err"}, resp_err, e_er);
    end else begin
      chk({tag, " valid early"}, resp_valid, 0);
      done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
        @(negedge clk);
        if (mode == 1) en = (k == 19) ? 1'b1 : 1'($urandom_range(0, 1));
        else if (mode == 2) en = (k > 0);
        else en = 1'b1;
        clk_en = en;
        #1;
        chk({tag, " busy"}, req_ready, 0);
        if (rmw && en) begin
          chk({tag, " rmw we"}, mem_we, 1);
          chk({tag, " rmw waddr"}, mem_waddr, wa);
          chk({tag, " rmw wdata"}, mem_wdata, rmw_wd);
        end else if (!rmw) begin
          chk({tag, " load we"}, mem_we, 0);
        end
        pv = resp_valid;
        @(posedge clk); #1;
        if (en) begin
          chk({tag, " valid"}, resp_valid, 1);
          chk({tag, " rdata"}, resp_rdata, e_rd);
          chk({tag, " err"}, resp_err, e_er);
          done = 1;
        end else begin
          chk({tag, " hold valid"}, resp_valid, pv);
          chk({tag, " hold busy"}, req_ready, 0);
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL %s timeout: no response within budget", tag);
      end
    end
    clk_en = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic        bt;
    logic        sg;
    logic [AW:0] addr;
    logic [15:0] wd;
    logic [15:0] rd;
    logic        er;
  } vec_t;

  vec_t vecs [11];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      dmem[i] = 16'h0; ref_mem[i] = 16'h0;
    end
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'hFFBE, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00EF, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0011, 16'h0012, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h12EF, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h1234, 16'h0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'hFFEF, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, 16'h0012, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0020, 16'h5A5A, 16'h0000, 1'b0};

    // Reset with a word store presented: nothing may be written.
    rst = 1'b1; clk_en = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = 16'h0010; req_wdata = 16'hDEAD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("reset valid", resp_valid, 0);
      chk("reset rdata", resp_rdata, 0);
      chk("reset err", resp_err, 0);
      chk("reset ready", req_ready, 1);
      chk("reset we", mem_we, 0);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;

    for (int i = 0; i < 11; i++)
      do_req(vecs[i].we, vecs[i].bt, vecs[i].sg, vecs[i].addr, vecs[i].wd,
             0, 1'b1, vecs[i].rd, vecs[i].er, $sformatf("vec%0d", i));

    // Load with clk_en pattern 1-0-1.
    do_req(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, 2, 1'b1, 16'h12EF, 1'b0, "clken load");

    // Reset landing in the RMW cycle of a byte store to 0x0020.
    @(negedge clk);
    clk_en = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1;
    req_signed = 1'b0; req_addr = 16'h0020; req_wdata = 16'h0077;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rstrmw busy", req_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstrmw we", mem_we, 0);
    chk("rstrmw valid", resp_valid, 0);
    chk("rstrmw rdata", resp_rdata, 0);
    chk("rstrmw err", resp_err, 0);
    @(posedge clk); #1;
    chk("rstrmw we edge", mem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstrmw ready", req_ready, 1);
    chk("rstrmw mem", dmem[16'h0010], 16'h5A5A);
    do_req(1'b0, 1'b0, 1'b0, 16'h0020, 16'h0, 0, 1'b1, 16'h5A5A, 1'b0, "rstrmw load");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom_range(0, 63)), 16'($urandom), $urandom_range(0, 1),
             1'b0, 16'h0, 1'b0, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        clk_en = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pulse clear", resp_valid, 0);
      end
    end

    for (int a = 0; a < 32; a++)
      chk($sformatf("final mem %0d", a), dmem[a], ref_mem[a]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit between the CPU execute stage and the 16-bit word-addressed data memory (1-cycle synchronous read).
- Accepts byte-addressed load/store requests and translates them to word accesses.
- Handles byte loads with zero or sign extension, and byte stores by read-modify-write.
- Detects misaligned word accesses; returns one response per request.

Parameters:
- ADDR_WIDTH, 15, data memory word-address width; the byte address is ADDR_WIDTH+1 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- clk_en  in  1  clock enable for speed control; all state advances only when high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request (state IDLE)
- req_we  in  1  1 = store, 0 = load
- req_byte  in  1  1 = byte access, 0 = word access
- req_signed  in  1  byte load sign-extends when 1
- req_addr  in  ADDR_WIDTH+1  byte address
- req_wdata  in  16  store data; byte stores use [7:0]
- resp_valid  out  1  response pulse
- resp_rdata  out  16  load result; 0 for stores and errors
- resp_err  out  1  misaligned word access
- mem_raddr  out  ADDR_WIDTH  data memory read address
- mem_waddr  out  ADDR_WIDTH  data memory write address
- mem_wdata  out  16  data memory write data
- mem_we  out  1  data memory write enable
- mem_rdata  in  16  data memory read data, valid 1 cycle after mem_raddr

Behaviour:
- "Cycle" means a rising clk edge with clk_en=1. With clk_en=0 all registers hold, including resp_valid. The consumer qualifies resp_valid with clk_en.
- Accept condition: req_valid & req_ready & clk_en. req_ready = (state==IDLE).
- Word address wa = req_addr[ADDR_WIDTH:1].
- Byte lanes are little-endian: addr[0]=0 selects [7:0]; addr[0]=1 selects [15:8].
- States: IDLE, LOAD, RMW, and a latched request register (wa, lane, signed, byte data).
- Word store, accepted at T:
  - During T, drive mem_we=1, mem_waddr=wa, mem_wdata=req_wdata combinationally.
  - Stay in IDLE.
  - resp_valid=1 at T+1 with resp_rdata=0, resp_err=0.
- Load, accepted at T:
  - During T, drive mem_raddr=wa; go to LOAD.
  - In LOAD (T+1), format mem_rdata:
    - word: pass through;
    - byte: selected lane, upper 8 bits zero-filled, or filled with bit 7 of the lane when signed.
  - Register the result into resp_rdata; return to IDLE.
  - resp_valid=1 at T+2.
- Byte store, accepted at T:
  - During T, drive mem_raddr=wa; go to RMW.
  - In RMW (T+1), drive mem_we=1, mem_waddr=latched wa, mem_wdata = mem_rdata with the selected lane replaced by latched data[7:0].
  - Return to IDLE; resp_valid=1 at T+2.
- Misaligned (req_byte=0 and req_addr[0]=1):
  - No memory access (mem_we=0); stay in IDLE.
  - resp_valid=1, resp_err=1, resp_rdata=0 at T+1.
- resp_valid is a 1-cycle pulse: cleared on the next cycle unless a new response is produced.
- A new request may be accepted in the same cycle that resp_valid is high, whenever the state is IDLE.
- mem_raddr in idle cycles with no accepted request: hold the last value (don't-care to dmem). mem_we=0 outside the accept cycle of a word store and the RMW state.
- mem_we is never asserted while rst=1.
- Reset (async) forces state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, and clears the latched request to 0.
  - Reset during LOAD or RMW abandons the operation; no write is issued.
  - A reset landing in RMW before the edge suppresses mem_we in that cycle.
- Throughput: word store or error, 1 request/cycle; load or byte store, 1 request per 2 cycles.

Test Plan:
- Word store addr 0x0010, data 0xBEEF, then word load 0x0010 -> store resp at T+1 with resp_err=0; load resp at T+2 with resp_rdata=0xBEEF.
- Word 0x0010=0xBEEF; byte load 0x0011, signed=1 -> 0xFFBE. Byte load 0x0010, signed=0 -> 0x00EF.
- Byte store 0x0011, data 0x12, over 0xBEEF -> mem_we in RMW cycle with mem_wdata=0x12EF; following word load returns 0x12EF; req_ready=0 during RMW.
- Word load at 0x0003 -> resp_valid and resp_err=1 at T+1, resp_rdata=0, mem_we never asserted; next request accepted the following cycle.
- clk_en toggled 1-0-1 during a load -> state and resp_valid hold while clk_en=0; result is identical to the clk_en=1 case.
- rst asserted in the RMW cycle of byte store 0x0020 -> mem_we stays 0, word 0x0020 unchanged, outputs 0, req_ready=1 after reset release.
